gray_bin_conv_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with valid/ready handshake and per-beat direction select. It converts W-bit Gray to binary (mode 0) or binary to Gray (mode 1) through a two-register pipeline with full backpressure. It sits on the pointer/counter path between synchroniser outputs and arithmetic consumers, and replaces fixed-width combinational converters. An optional checker flags Gray inputs that violate the single-bit-change rule.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_step_chk.sv | 43 ++++
 rtl/gray_bin_conv_pipe.sv | 95 +++++++++
 tb/tb_gray_bin_conv_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers and constants for the converter pipeline.
// Latency: n/a (pure functions). Backpressure: n/a.
// Functions work on MAX_W bits; narrower words are zero-extended, which leaves both conversions exact.
package gray_pkg;

    localparam int   MAX_W     = 32;
    localparam int   ERR_CNT_W = 8;
    localparam logic MODE_G2B  = 1'b0;
    localparam logic MODE_B2G  = 1'b1;

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Gray single-step checker: flags mode-0 words differing from the previous mode-0 word in >=2 bits.
// Latency: chk_err is combinational on the presented word; history and err_cnt update on chk_vld.
// Backpressure: none; chk_vld must pulse exactly once per beat, in beat order.
module gray_step_chk
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_vld,
    input  logic [W-1:0]         chk_dat,
    input  logic                 chk_mode,
    output logic                 chk_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic         hist_vld;
    logic [W-1:0] hist_dat;
    logic [W-1:0] diff;

    assign diff = chk_dat ^ hist_dat;

    // Clearing the lowest set bit leaves something only when two or more bits differ.
    assign chk_err = (chk_mode == MODE_G2B) && hist_vld && (|(diff & (diff - W'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld <= 1'b0;
            hist_dat <= '0;
            err_cnt  <= '0;
        end else if (chk_vld) begin
            if (chk_mode == MODE_G2B) begin
                hist_vld <= 1'b1;
                hist_dat <= chk_dat;
            end
            if (chk_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Two-stage Gray<->binary converter, direction chosen per beat; optional Gray step checker under GRAY_CHECK_EN.
// Latency: 2 cycles accept-to-valid, 1 beat/cycle while out_ready is high.
// Backpressure: full valid/ready; in_ready is combinational from out_ready, output held while stalled.
module gray_bin_conv_pipe
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_mode
`ifdef GRAY_CHECK_EN
    ,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic         s1_vld;
    logic         s1_mode;
    logic [W-1:0] s1_dat;
    logic         s2_vld;
    logic         s1_adv;
    logic         s2_adv;
    logic [W-1:0] conv_dat;

    assign s2_adv    = !s2_vld || out_ready;
    assign s1_adv    = !s1_vld || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_vld;

    assign conv_dat = (s1_mode == MODE_B2G) ? W'(bin2gray(MAX_W'(s1_dat)))
                                            : W'(gray2bin(MAX_W'(s1_dat)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s1_mode <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat  <= in_data;
                s1_mode <= in_mode;
            end
        end
    end

    // Payload only loads with a real beat so a drained output keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            out_data <= '0;
            out_mode <= 1'b0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                out_data <= conv_dat;
                out_mode <= s1_mode;
            end
        end
    end

`ifdef GRAY_CHECK_EN
    logic chk_err;

    gray_step_chk #(
        .W (W)
    ) u_step_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .chk_vld  (s1_vld && s2_adv),
        .chk_dat  (s1_dat),
        .chk_mode (s1_mode),
        .chk_err  (chk_err),
        .err_cnt  (err_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (s2_adv && s1_vld) begin
            out_err <= chk_err;
        end
    end
`endif

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for gray_bin_conv_pipe (W=4); checker scenarios compile in with GRAY_CHECK_EN.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// Stalls are produced by holding out_ready low.
module tb_gray_bin_conv_pipe;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
`ifdef GRAY_CHECK_EN
    logic         out_err;
    logic [7:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_bin_conv_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
`ifdef GRAY_CHECK_EN
        ,
        .out_err   (out_err),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic drive(input logic v, input logic [W-1:0] d, input logic m, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = r;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset_out_data: got %b expected 0000", out_data); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode: got %b expected 0", out_mode); end
`ifdef GRAY_CHECK_EN
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single(input string name, input logic m, input logic [W-1:0] d, input logic [W-1:0] exp);
        drive(1'b1, d, m, 1'b1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept: got in_ready=%b expected 1", name, in_ready); end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: got out_valid=%b expected 0", name, out_valid); end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got out_valid=%b expected 1", name, out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL %s_data: got %b expected %b", name, out_data, exp); end
        checks++; if (out_mode !== m) begin errors++; $display("FAIL %s_mode: got %b expected %b", name, out_mode, m); end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: got out_valid=%b expected 0", name, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] din [3];
        logic [W-1:0] exp [3];
        logic         mod [3];
        din = '{4'b0110, 4'b0101, 4'b1111};
        mod = '{1'b0, 1'b1, 1'b0};
        exp = '{4'b0100, 4'b0111, 4'b1010};
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b1, din[c], mod[c], 1'b1);
            else       drive(1'b0, '0, 1'b0, 1'b1);
            if (c < 3) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", c, in_ready); end
            end
            if (c >= 2) begin
                checks++;
                if ({out_valid, out_mode, out_data} !== {1'b1, mod[c-2], exp[c-2]}) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b m=%b d=%b expected v=1 m=%b d=%b",
                             c - 2, out_valid, out_mode, out_data, mod[c-2], exp[c-2]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] gseq [16];
        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        apply_reset();
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drive(1'b1, gseq[c], 1'b0, 1'b1);
            else        drive(1'b0, '0, 1'b0, 1'b1);
            if (c >= 2) begin
                checks++;
                if ({out_valid, out_data} !== {1'b1, W'(c - 2)}) begin
                    errors++;
                    $display("FAIL sweep[%0d]: got v=%b d=%b expected v=1 d=%b", c - 2, out_valid, out_data, W'(c - 2));
                end
`ifdef GRAY_CHECK_EN
                checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL sweep_err[%0d]: got %b expected 0", c - 2, out_err); end
`endif
            end
        end
`ifdef GRAY_CHECK_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL sweep_err_cnt: got %0d expected 0", err_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        logic [W-1:0] din [5];
        logic [W-1:0] exp [5];
        int sent = 0;
        int rcvd = 0;
        din = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
        exp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, din[sent], 1'b1, 1'b0);
            if (c >= 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready); end
                checks++;
                if ({out_valid, out_data} !== {1'b1, exp[0]}) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: got v=%b d=%b expected v=1 d=%b", c, out_valid, out_data, exp[0]);
                end
            end
            if (in_ready) sent++;
        end
        checks++; if (sent !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", sent); end
        for (int c = 0; c < 20 && rcvd < 5; c++) begin
            if (sent < 5) drive(1'b1, din[sent], 1'b1, 1'b1);
            else          drive(1'b0, '0, 1'b0, 1'b1);
            if (out_valid) begin
                checks++;
                if (out_data !== exp[rcvd]) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %b expected %b", rcvd, out_data, exp[rcvd]);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        checks++; if (rcvd !== 5) begin errors++; $display("FAIL bp_delivered: got %0d expected 5", rcvd); end
    endtask

`ifdef GRAY_CHECK_EN
    task automatic test_checker();
        logic [W-1:0] din  [6];
        logic         mod  [6];
        logic         eerr [6];
        logic [7:0]   ecnt [6];
        din  = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b1111, 4'b0011};
        mod  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        eerr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ecnt = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 6) drive(1'b1, din[c], mod[c], 1'b1);
            else       drive(1'b0, '0, 1'b0, 1'b1);
            if (c >= 2) begin
                checks++;
                if ({out_valid, out_err, err_cnt} !== {1'b1, eerr[c-2], ecnt[c-2]}) begin
                    errors++;
                    $display("FAIL chk_beat[%0d]: got v=%b err=%b cnt=%0d expected v=1 err=%b cnt=%0d",
                             c - 2, out_valid, out_err, err_cnt, eerr[c-2], ecnt[c-2]);
                end
            end
        end
        for (int i = 0; i < 300; i++) drive(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b0, 1'b1);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL chk_saturate: got %0d expected 255", err_cnt); end
    endtask
`endif

    task automatic test_reset_midstream();
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL mid_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
`ifdef GRAY_CHECK_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d expected 0", err_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b1111, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_data} !== {1'b1, 4'b1010}) begin
            errors++;
            $display("FAIL post_rst_beat: got v=%b d=%b expected v=1 d=1010", out_valid, out_data);
        end
`ifdef GRAY_CHECK_EN
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL post_rst_err: got %b expected 0", out_err); end
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single("g2b", 1'b0, 4'b0110, 4'b0100);
        test_single("b2g", 1'b1, 4'b0101, 4'b0111);
        test_back_to_back();
        test_sweep();
        test_backpressure();
`ifdef GRAY_CHECK_EN
        test_checker();
`endif
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
